data_path_pipe: RTL

Parametrised, pipelined successor to the single-cycle register-bank/ALU datapath. It combines an NREGS x WIDTH register file, Rdest/Rsrc operand selection, an immediate mux, an ALU and a flags register. These are arranged as a 2-stage pipeline (operand-latch -> execute/write-back) with a valid/ready handshake, write-back-to-operand forwarding and backpressure stall. It sits between the instruction decoder (upstream) and any result consumer (downstream).

---
 rtl/data_path_pipe.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_path_pipe.sv
// Two-stage (operand latch -> execute/write-back) register-file/ALU datapath with forwarding and backpressure.
// Optional debug read port enabled by defining DATA_PATH_DBG_EN.
module data_path_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    localparam int RSEL_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [RSEL_W-1:0] rdest_sel,
    input  logic [RSEL_W-1:0] rsrc_sel,
    input  logic [WIDTH-1:0]  imm_in,
    input  logic              imm_select,
    input  logic              wb_en,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    input  logic              out_ready,
    output logic [4:0]        flags
`ifdef DATA_PATH_DBG_EN
    ,
    input  logic [RSEL_W-1:0] dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
`endif
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;
    localparam logic [3:0] OP_RSH = 4'd8;

    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];

    logic              e_valid_q, e_valid_d;
    logic [3:0]        e_op_q, e_op_d;
    logic [RSEL_W-1:0] e_dest_q, e_dest_d;
    logic              e_wb_q, e_wb_d;
    logic [WIDTH-1:0]  e_a_q, e_a_d;
    logic [WIDTH-1:0]  e_b_q, e_b_d;

    logic [WIDTH-1:0]  result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic [4:0]        flags_q, flags_d;

    logic              adv;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c, alu_l, alu_f;
    logic              alu_flag_upd;
    logic              alu_wb_ok;
    logic              e_wb_eff;
    logic [4:0]        alu_flags;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;

    assign adv          = !result_valid_q || out_ready;
    assign in_ready     = adv;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign flags        = flags_q;

`ifdef DATA_PATH_DBG_EN
    assign dbg_data = regs_q[dbg_sel];
`endif

    // ALU on the latched E-stage operands
    always_comb begin
        sum_ext      = {1'b0, e_a_q} + {1'b0, e_b_q};
        diff_ext     = {1'b0, e_a_q} - {1'b0, e_b_q};
        alu_res      = '0;
        alu_c        = 1'b0;
        alu_l        = 1'b0;
        alu_f        = 1'b0;
        alu_flag_upd = 1'b0;
        alu_wb_ok    = 1'b0;
        case (e_op_q)
            OP_ADD: begin
                alu_res      = sum_ext[WIDTH-1:0];
                alu_c        = sum_ext[WIDTH];
                alu_f        = (e_a_q[WIDTH-1] == e_b_q[WIDTH-1]) &&
                               (sum_ext[WIDTH-1] != e_a_q[WIDTH-1]);
                alu_flag_upd = 1'b1;
                alu_wb_ok    = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res      = diff_ext[WIDTH-1:0];
                alu_c        = diff_ext[WIDTH];
                alu_l        = diff_ext[WIDTH];
                alu_f        = (e_a_q[WIDTH-1] != e_b_q[WIDTH-1]) &&
                               (diff_ext[WIDTH-1] != e_a_q[WIDTH-1]);
                alu_flag_upd = 1'b1;
                alu_wb_ok    = (e_op_q == OP_SUB);
            end
            OP_AND: begin
                alu_res   = e_a_q & e_b_q;
                alu_wb_ok = 1'b1;
            end
            OP_OR: begin
                alu_res   = e_a_q | e_b_q;
                alu_wb_ok = 1'b1;
            end
            OP_XOR: begin
                alu_res   = e_a_q ^ e_b_q;
                alu_wb_ok = 1'b1;
            end
            OP_MOV: begin
                alu_res   = e_b_q;
                alu_wb_ok = 1'b1;
            end
            OP_LSH: begin
                alu_res   = e_a_q << e_b_q[SH_W-1:0];
                alu_wb_ok = 1'b1;
            end
            OP_RSH: begin
                alu_res   = e_a_q >> e_b_q[SH_W-1:0];
                alu_wb_ok = 1'b1;
            end
            default: begin
                alu_res   = '0;
                alu_wb_ok = 1'b0;
            end
        endcase
        alu_flags = {alu_c, alu_l, alu_f, (alu_res == '0), alu_res[WIDTH-1]};
        e_wb_eff  = e_wb_q && alu_wb_ok;
    end

    // Operand read with bypass from the instruction completing this cycle
    always_comb begin
        if (e_valid_q && e_wb_eff && (e_dest_q == rdest_sel)) begin
            op_a = alu_res;
        end else begin
            op_a = regs_q[rdest_sel];
        end
        if (imm_select) begin
            op_b = imm_in;
        end else if (e_valid_q && e_wb_eff && (e_dest_q == rsrc_sel)) begin
            op_b = alu_res;
        end else begin
            op_b = regs_q[rsrc_sel];
        end
    end

    // Next-state: everything holds unless the pipeline advances
    always_comb begin
        regs_d         = regs_q;
        e_valid_d      = e_valid_q;
        e_op_d         = e_op_q;
        e_dest_d       = e_dest_q;
        e_wb_d         = e_wb_q;
        e_a_d          = e_a_q;
        e_b_d          = e_b_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        flags_d        = flags_q;
        if (adv) begin
            e_valid_d = in_valid;
            if (in_valid) begin
                e_op_d   = opcode;
                e_dest_d = rdest_sel;
                e_wb_d   = wb_en;
                e_a_d    = op_a;
                e_b_d    = op_b;
            end else begin
                e_op_d   = e_op_q;
            end
            if (e_valid_q) begin
                result_d       = alu_res;
                result_valid_d = 1'b1;
                if (alu_flag_upd) begin
                    flags_d = alu_flags;
                end else begin
                    flags_d = flags_q;
                end
                if (e_wb_eff) begin
                    regs_d[e_dest_q] = alu_res;
                end else begin
                    regs_d[e_dest_q] = regs_q[e_dest_q];
                end
            end else begin
                result_valid_d = 1'b0;
            end
        end else begin
            e_valid_d = e_valid_q;
        end
    end

    // State registers with synchronous reset; an E-stage instruction is dropped on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q         <= '{default: '0};
            e_valid_q      <= 1'b0;
            e_op_q         <= 4'd0;
            e_dest_q       <= '0;
            e_wb_q         <= 1'b0;
            e_a_q          <= '0;
            e_b_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= 5'd0;
        end else begin
            regs_q         <= regs_d;
            e_valid_q      <= e_valid_d;
            e_op_q         <= e_op_d;
            e_dest_q       <= e_dest_d;
            e_wb_q         <= e_wb_d;
            e_a_q          <= e_a_d;
            e_b_q          <= e_b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            flags_q        <= flags_d;
        end
    end

endmodule
